// File: rtl/axi_timer.sv
// AXI4 slave exposing the RISC-V machine timer (64-bit mtime/mtimecmp) and its interrupt.
// Optional macro MTIME_PRESCALE_EN divides the mtime tick by PRESCALE clk cycles.
module axi_timer #(
    parameter logic [31:0] MTIME_ADDR    = 32'h0200_BFF8,
    parameter logic [31:0] MTIMECMP_ADDR = 32'h0200_4000,
    parameter logic [15:0] PRESCALE      = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid_timer,
    input  logic [3:0]  awid_timer,
    input  logic [31:0] awaddr_timer,
    input  logic [7:0]  awlen_timer,
    input  logic [2:0]  awsize_timer,
    input  logic [1:0]  awburst_timer,
    output logic        awready_timer,
    input  logic        wvalid_timer,
    input  logic [63:0] wdata_timer,
    input  logic [7:0]  wstrb_timer,
    input  logic        wlast_timer,
    output logic        wready_timer,
    output logic        bvalid_timer,
    output logic [3:0]  bid_timer,
    output logic [1:0]  bresp_timer,
    input  logic        bready_timer,
    input  logic        arvalid_timer,
    input  logic [3:0]  arid_timer,
    input  logic [31:0] araddr_timer,
    input  logic [7:0]  arlen_timer,
    input  logic [2:0]  arsize_timer,
    input  logic [1:0]  arburst_timer,
    output logic        arready_timer,
    output logic        rvalid_timer,
    output logic [3:0]  rid_timer,
    output logic [63:0] rdata_timer,
    output logic [1:0]  rresp_timer,
    output logic        rlast_timer,
    input  logic        rready_timer,
    output logic        timer_irq_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [63:0] byte_merge(
        input logic [63:0] old_v,
        input logic [63:0] new_v,
        input logic [7:0]  strb
    );
        logic [63:0] merged;
        for (int i = 0; i < 8; i++) begin
            merged[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return merged;
    endfunction

    w_state_t    w_state_r;
    w_state_t    w_state_s;
    r_state_t    r_state_r;
    r_state_t    r_state_s;

    logic [3:0]  awid_r;
    logic        w_sel_mtime_r;
    logic        w_sel_cmp_r;
    logic        w_err_r;

    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;

    logic        aw_hs_s;
    logic        w_hs_s;
    logic        b_hs_s;
    logic        ar_hs_s;
    logic        r_hs_s;
    logic        aw_hit_mtime_s;
    logic        aw_hit_cmp_s;
    logic        aw_err_s;
    logic        ar_hit_mtime_s;
    logic        ar_hit_cmp_s;
    logic        ar_err_s;
    logic [63:0] rd_value_s;
    logic        wr_mtime_s;
    logic        wr_cmp_s;
    logic        tick_s;
    logic        unused_s;

    assign aw_hs_s = awvalid_timer && awready_timer;
    assign w_hs_s  = wvalid_timer && wready_timer;
    assign b_hs_s  = bvalid_timer && bready_timer;
    assign ar_hs_s = arvalid_timer && arready_timer;
    assign r_hs_s  = rvalid_timer && rready_timer;

    // Only address bits [31:3] select a register; size/burst fields carry no meaning here.
    assign aw_hit_mtime_s = (awaddr_timer[31:3] == MTIME_ADDR[31:3]);
    assign aw_hit_cmp_s   = (awaddr_timer[31:3] == MTIMECMP_ADDR[31:3]);
    assign aw_err_s       = !(aw_hit_mtime_s || aw_hit_cmp_s) || (awlen_timer != 8'd0);
    assign ar_hit_mtime_s = (araddr_timer[31:3] == MTIME_ADDR[31:3]);
    assign ar_hit_cmp_s   = (araddr_timer[31:3] == MTIMECMP_ADDR[31:3]);
    assign ar_err_s       = !(ar_hit_mtime_s || ar_hit_cmp_s) || (arlen_timer != 8'd0);

    assign wr_mtime_s = w_hs_s && w_sel_mtime_r && !w_err_r;
    assign wr_cmp_s   = w_hs_s && w_sel_cmp_r && !w_err_r;

    assign unused_s = ^{awsize_timer, awburst_timer, arsize_timer, arburst_timer,
                        awaddr_timer[2:0], araddr_timer[2:0]};

`ifdef MTIME_PRESCALE_EN
    localparam logic [15:0] PRESCALE_EFF = (PRESCALE == 16'd0) ? 16'd1 : PRESCALE;

    logic [15:0] presc_cnt_r;

    assign tick_s = (presc_cnt_r >= (PRESCALE_EFF - 16'd1));

    // Prescale counter: counts 0..PRESCALE_EFF-1, a tick fires on the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_r <= 16'd0;
        end else if (tick_s) begin
            presc_cnt_r <= 16'd0;
        end else begin
            presc_cnt_r <= presc_cnt_r + 16'd1;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    // Write FSM next-state logic.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) begin
                    w_state_s = W_DATA;
                end else begin
                    w_state_s = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_hs_s && wlast_timer) begin
                    w_state_s = W_RESP;
                end else begin
                    w_state_s = W_DATA;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_s = W_IDLE;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write FSM state, registered AW/W/B handshake outputs and the latched AW attributes.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r     <= W_IDLE;
            awready_timer <= 1'b1;
            wready_timer  <= 1'b0;
            bvalid_timer  <= 1'b0;
            bid_timer     <= 4'd0;
            bresp_timer   <= 2'b00;
            awid_r        <= 4'd0;
            w_sel_mtime_r <= 1'b0;
            w_sel_cmp_r   <= 1'b0;
            w_err_r       <= 1'b0;
        end else begin
            w_state_r     <= w_state_s;
            awready_timer <= (w_state_s == W_IDLE);
            wready_timer  <= (w_state_s == W_DATA);
            bvalid_timer  <= (w_state_s == W_RESP);
            if (aw_hs_s) begin
                awid_r        <= awid_timer;
                w_sel_mtime_r <= aw_hit_mtime_s;
                w_sel_cmp_r   <= aw_hit_cmp_s && !aw_hit_mtime_s;
                w_err_r       <= aw_err_s;
            end
            if (w_hs_s && wlast_timer) begin
                bid_timer   <= awid_r;
                bresp_timer <= w_err_r ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Timer registers: a software write to mtime takes priority over the tick increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_r     <= 64'd0;
            mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
            timer_irq_o <= 1'b0;
        end else begin
            if (wr_mtime_s) begin
                mtime_r <= byte_merge(mtime_r, wdata_timer, wstrb_timer);
            end else if (tick_s) begin
                mtime_r <= mtime_r + 64'd1;
            end
            if (wr_cmp_s) begin
                mtimecmp_r <= byte_merge(mtimecmp_r, wdata_timer, wstrb_timer);
            end
            timer_irq_o <= (mtime_r >= mtimecmp_r);
        end
    end

    // Read data selection at the AR handshake; errors return zero data.
    always_comb begin
        rd_value_s = 64'd0;
        if (ar_err_s) begin
            rd_value_s = 64'd0;
        end else if (ar_hit_mtime_s) begin
            rd_value_s = mtime_r;
        end else begin
            rd_value_s = mtimecmp_r;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_s = R_DATA;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read FSM state and registered R channel payload, held until the R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r     <= R_IDLE;
            arready_timer <= 1'b1;
            rvalid_timer  <= 1'b0;
            rid_timer     <= 4'd0;
            rdata_timer   <= 64'd0;
            rresp_timer   <= 2'b00;
            rlast_timer   <= 1'b0;
        end else begin
            r_state_r     <= r_state_s;
            arready_timer <= (r_state_s == R_IDLE);
            rvalid_timer  <= (r_state_s == R_DATA);
            if (ar_hs_s) begin
                rid_timer   <= arid_timer;
                rdata_timer <= rd_value_s;
                rresp_timer <= ar_err_s ? RESP_SLVERR : RESP_OKAY;
                rlast_timer <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_timer.sv
// Directed self-checking bench for axi_timer in its default build (one mtime tick per clk).
module tb_axi_timer;

    localparam logic [31:0] A_MTIME = 32'h0200_BFF8;
    localparam logic [31:0] A_CMP   = 32'h0200_4000;
    localparam logic [31:0] A_BAD   = 32'h0200_0010;

    logic        clk;
    logic        rst;
    logic        awvalid_timer;
    logic [3:0]  awid_timer;
    logic [31:0] awaddr_timer;
    logic [7:0]  awlen_timer;
    logic [2:0]  awsize_timer;
    logic [1:0]  awburst_timer;
    logic        awready_timer;
    logic        wvalid_timer;
    logic [63:0] wdata_timer;
    logic [7:0]  wstrb_timer;
    logic        wlast_timer;
    logic        wready_timer;
    logic        bvalid_timer;
    logic [3:0]  bid_timer;
    logic [1:0]  bresp_timer;
    logic        bready_timer;
    logic        arvalid_timer;
    logic [3:0]  arid_timer;
    logic [31:0] araddr_timer;
    logic [7:0]  arlen_timer;
    logic [2:0]  arsize_timer;
    logic [1:0]  arburst_timer;
    logic        arready_timer;
    logic        rvalid_timer;
    logic [3:0]  rid_timer;
    logic [63:0] rdata_timer;
    logic [1:0]  rresp_timer;
    logic        rlast_timer;
    logic        rready_timer;
    logic        timer_irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  resp;
    logic [3:0]  id;
    logic [63:0] data;
    logic        last;

    axi_timer dut (
        .clk(clk), .rst(rst),
        .awvalid_timer(awvalid_timer), .awid_timer(awid_timer), .awaddr_timer(awaddr_timer),
        .awlen_timer(awlen_timer), .awsize_timer(awsize_timer), .awburst_timer(awburst_timer),
        .awready_timer(awready_timer),
        .wvalid_timer(wvalid_timer), .wdata_timer(wdata_timer), .wstrb_timer(wstrb_timer),
        .wlast_timer(wlast_timer), .wready_timer(wready_timer),
        .bvalid_timer(bvalid_timer), .bid_timer(bid_timer), .bresp_timer(bresp_timer),
        .bready_timer(bready_timer),
        .arvalid_timer(arvalid_timer), .arid_timer(arid_timer), .araddr_timer(araddr_timer),
        .arlen_timer(arlen_timer), .arsize_timer(arsize_timer), .arburst_timer(arburst_timer),
        .arready_timer(arready_timer),
        .rvalid_timer(rvalid_timer), .rid_timer(rid_timer), .rdata_timer(rdata_timer),
        .rresp_timer(rresp_timer), .rlast_timer(rlast_timer), .rready_timer(rready_timer),
        .timer_irq_o(timer_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] wid, input logic [7:0] len,
                            input int beats, input logic [63:0] wd, input logic [7:0] strb,
                            output logic [1:0] bresp_o, output logic [3:0] bid_o);
        awvalid_timer = 1'b1; awid_timer = wid; awaddr_timer = addr; awlen_timer = len;
        awsize_timer = 3'd3; awburst_timer = 2'b01;
        wvalid_timer = 1'b1; wdata_timer = wd; wstrb_timer = strb; wlast_timer = (beats == 1);
        for (int n = 0; n < 20 && !awready_timer; n++) begin @(posedge clk); #1; end
        chk("aw_ready", 64'(awready_timer), 64'd1);
        @(posedge clk); #1;
        awvalid_timer = 1'b0;
        for (int b = 0; b < beats; b++) begin
            wlast_timer = (b == beats - 1);
            for (int n = 0; n < 20 && !wready_timer; n++) begin @(posedge clk); #1; end
            chk("w_ready", 64'(wready_timer), 64'd1);
            @(posedge clk); #1;
        end
        wvalid_timer = 1'b0; wlast_timer = 1'b0;
        for (int n = 0; n < 20 && !bvalid_timer; n++) begin @(posedge clk); #1; end
        chk("b_valid", 64'(bvalid_timer), 64'd1);
        bresp_o = bresp_timer;
        bid_o   = bid_timer;
        bready_timer = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] rdid, input logic [7:0] len,
                           output logic [63:0] rd_o, output logic [1:0] rresp_o,
                           output logic rlast_o, output logic [3:0] rid_o);
        arvalid_timer = 1'b1; arid_timer = rdid; araddr_timer = addr; arlen_timer = len;
        arsize_timer = 3'd3; arburst_timer = 2'b01;
        for (int n = 0; n < 20 && !arready_timer; n++) begin @(posedge clk); #1; end
        chk("ar_ready", 64'(arready_timer), 64'd1);
        @(posedge clk); #1;
        arvalid_timer = 1'b0;
        for (int n = 0; n < 20 && !rvalid_timer; n++) begin @(posedge clk); #1; end
        chk("r_valid", 64'(rvalid_timer), 64'd1);
        rd_o = rdata_timer; rresp_o = rresp_timer; rlast_o = rlast_timer; rid_o = rid_timer;
        rready_timer = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        awvalid_timer = 1'b0; awid_timer = 4'd0; awaddr_timer = 32'd0; awlen_timer = 8'd0;
        awsize_timer = 3'd0; awburst_timer = 2'd0;
        wvalid_timer = 1'b0; wdata_timer = 64'd0; wstrb_timer = 8'd0; wlast_timer = 1'b0;
        bready_timer = 1'b1;
        arvalid_timer = 1'b0; arid_timer = 4'd0; araddr_timer = 32'd0; arlen_timer = 8'd0;
        arsize_timer = 3'd0; arburst_timer = 2'd0;
        rready_timer = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_awready", 64'(awready_timer), 64'd1);
        chk("rst_arready", 64'(arready_timer), 64'd1);
        chk("rst_wready",  64'(wready_timer),  64'd0);
        chk("rst_bvalid",  64'(bvalid_timer),  64'd0);
        chk("rst_rvalid",  64'(rvalid_timer),  64'd0);
        chk("rst_irq",     64'(timer_irq_o),   64'd0);
        chk("rst_bid",     64'(bid_timer),     64'd0);
        chk("rst_bresp",   64'(bresp_timer),   64'd0);
        chk("rst_rid",     64'(rid_timer),     64'd0);
        chk("rst_rresp",   64'(rresp_timer),   64'd0);
        chk("rst_rdata",   rdata_timer,        64'd0);
        chk("rst_rlast",   64'(rlast_timer),   64'd0);

        // Ten idle cycles: mtime is 10 at the AR handshake
        repeat (10) @(posedge clk);
        #1;
        do_read(A_MTIME, 4'h1, 8'd0, data, resp, last, id);
        chk("rd_mtime10_data", data, 64'd10);
        chk("rd_mtime10_resp", 64'(resp), 64'd0);
        chk("rd_mtime10_last", 64'(last), 64'd1);
        chk("rd_mtime10_rid",  64'(id),   64'h1);

        // mtimecmp=20 written while mtime ~14; irq rises one cycle after mtime reaches 20
        do_write(A_CMP, 4'h2, 8'd0, 1, 64'd20, 8'hFF, resp, id);
        chk("wr_cmp_bresp", 64'(resp), 64'd0);
        chk("wr_cmp_bid",   64'(id),   64'h2);
        chk("irq_pre",      64'(timer_irq_o), 64'd0);
        for (int k = 16; k <= 22; k++) begin
            @(posedge clk); #1;
            chk("irq_rise", 64'(timer_irq_o), 64'(k >= 21));
        end
        do_read(A_CMP, 4'h3, 8'd0, data, resp, last, id);
        chk("rd_cmp_data", data, 64'd20);

        // Strobed mtime write lands in the same cycle as a tick: merged value wins
        do_write(A_MTIME, 4'h4, 8'd0, 1, 64'h0000_0000_ABCC_FFFE, 8'hFF, resp, id);
        chk("wr_mtime_full_bresp", 64'(resp), 64'd0);
        do_write(A_MTIME, 4'h5, 8'd0, 1, 64'hFFFF_FFFF_FFFF_1234, 8'h03, resp, id);
        chk("wr_mtime_strb_bresp", 64'(resp), 64'd0);
        do_read(A_MTIME, 4'h6, 8'd0, data, resp, last, id);
        chk("rd_mtime_merge", data, 64'h0000_0000_ABCD_1235);

        // Error responses: unmapped address, and burst to a mapped one
        do_write(A_BAD, 4'hA, 8'd1, 2, 64'd5, 8'hFF, resp, id);
        chk("wr_bad_bresp", 64'(resp), 64'd2);
        chk("wr_bad_bid",   64'(id),   64'hA);
        do_write(A_CMP, 4'h7, 8'd1, 2, 64'd5, 8'hFF, resp, id);
        chk("wr_burst_bresp", 64'(resp), 64'd2);
        do_read(A_CMP, 4'h8, 8'd0, data, resp, last, id);
        chk("rd_cmp_unchanged", data, 64'd20);
        chk("rd_cmp_unch_resp", 64'(resp), 64'd0);
        do_read(A_BAD, 4'h5, 8'd0, data, resp, last, id);
        chk("rd_bad_resp", 64'(resp), 64'd2);
        chk("rd_bad_data", data,      64'd0);
        chk("rd_bad_last", 64'(last), 64'd1);
        chk("rd_bad_rid",  64'(id),   64'h5);
        do_read(A_MTIME, 4'h9, 8'd1, data, resp, last, id);
        chk("rd_burst_resp", 64'(resp), 64'd2);
        chk("rd_burst_data", data,      64'd0);

        // Concurrent write and read with both responses stalled for 5 cycles
        bready_timer = 1'b0; rready_timer = 1'b0;
        awvalid_timer = 1'b1; awid_timer = 4'h3; awaddr_timer = A_CMP; awlen_timer = 8'd0;
        wvalid_timer = 1'b1; wdata_timer = 64'd1000; wstrb_timer = 8'hFF; wlast_timer = 1'b1;
        arvalid_timer = 1'b1; arid_timer = 4'h6; araddr_timer = A_CMP; arlen_timer = 8'd0;
        @(posedge clk); #1;
        awvalid_timer = 1'b0; arvalid_timer = 1'b0;
        chk("stall_wready", 64'(wready_timer), 64'd1);
        chk("stall_rvalid1", 64'(rvalid_timer), 64'd1);
        @(posedge clk); #1;
        wvalid_timer = 1'b0; wlast_timer = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_bvalid", 64'(bvalid_timer), 64'd1);
            chk("stall_bid",    64'(bid_timer),    64'h3);
            chk("stall_bresp",  64'(bresp_timer),  64'd0);
            chk("stall_rvalid", 64'(rvalid_timer), 64'd1);
            chk("stall_rid",    64'(rid_timer),    64'h6);
            chk("stall_rdata",  rdata_timer,       64'd20);
            chk("stall_rlast",  64'(rlast_timer),  64'd1);
            @(posedge clk); #1;
        end
        bready_timer = 1'b1; rready_timer = 1'b1;
        @(posedge clk); #1;
        chk("stall_bvalid_done", 64'(bvalid_timer), 64'd0);
        chk("stall_rvalid_done", 64'(rvalid_timer), 64'd0);
        do_read(A_CMP, 4'h1, 8'd0, data, resp, last, id);
        chk("rd_cmp_1000", data, 64'd1000);

        // Reset in W_DATA aborts the write
        awvalid_timer = 1'b1; awid_timer = 4'h9; awaddr_timer = A_CMP; awlen_timer = 8'd0;
        @(posedge clk); #1;
        awvalid_timer = 1'b0;
        chk("mid_wready", 64'(wready_timer), 64'd1);
        wvalid_timer = 1'b1; wdata_timer = 64'd7; wstrb_timer = 8'hFF; wlast_timer = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wvalid_timer = 1'b0; wlast_timer = 1'b0;
        chk("mid_awready", 64'(awready_timer), 64'd1);
        chk("mid_bvalid",  64'(bvalid_timer),  64'd0);
        chk("mid_wready0", 64'(wready_timer),  64'd0);
        chk("mid_irq",     64'(timer_irq_o),   64'd0);
        do_read(A_CMP, 4'h2, 8'd0, data, resp, last, id);
        chk("mid_cmp_ones", data, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(A_MTIME, 4'h3, 8'd0, data, resp, last, id);
        chk("mid_mtime2", data, 64'd2);

        // mtime wraps from all ones to zero; irq follows mtime >= all-ones compare
        do_write(A_MTIME, 4'h4, 8'd0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, resp, id);
        chk("wrap_irq0", 64'(timer_irq_o), 64'd0);
        @(posedge clk); #1;
        chk("wrap_irq1", 64'(timer_irq_o), 64'd1);
        @(posedge clk); #1;
        chk("wrap_irq2", 64'(timer_irq_o), 64'd0);
        do_read(A_MTIME, 4'h5, 8'd0, data, resp, last, id);
        chk("wrap_mtime", data, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
